// File: rtl/dispatch_ctrl_if.sv
// Handshake bundle between ifetch, the dispatch sequencer and the decoder.
// The slave modport is the dispatch_ctrl view; the master modport is the environment view.
interface dispatch_ctrl_if;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_is_jump;
  logic        if_ready;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_is_jump;

  modport slave (
    input  if_valid, if_inst, if_pc, if_is_jump,
    output if_ready, dec_valid, dec_inst, dec_pc, dec_is_jump
  );

  modport master (
    output if_valid, if_inst, if_pc, if_is_jump,
    input  if_ready, dec_valid, dec_inst, dec_pc, dec_is_jump
  );
endinterface

// File: rtl/dispatch_ctrl.sv
// In-order dispatch sequencer: buffers fetched instructions and releases at most one per
// cycle when the ROB and the target unit (RS or LSB) have room; flushes on rollback.
module dispatch_ctrl #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback,
  input  logic                rob_full,
  input  logic                rs_full,
  input  logic                lsb_full,
  dispatch_ctrl_if.slave      bus,
  output logic [31:0]         stall_cycles
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        is_jump;
  } entry_t;

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  state_t                  state_q, state_d;
  entry_t [DEPTH-1:0]      fifo_q, fifo_d;
  logic   [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic   [PTR_W:0]        count_q, count_d;
  logic                    dec_valid_q, dec_valid_d;
  entry_t                  dec_q, dec_d;
  logic   [31:0]           stall_q, stall_d;

  entry_t                  head_entry;
  logic                    head_valid, is_lsb, blocked, if_ready, push, issue;

  assign head_entry = fifo_q[head_q];
  assign head_valid = (count_q != '0);
  assign is_lsb     = (head_entry.inst[6:0] == 7'b0000011) ||
                      (head_entry.inst[6:0] == 7'b0100011);
  assign blocked    = head_valid && (rob_full || (is_lsb ? lsb_full : rs_full));

  // if_ready looks only at registered state so ifetch never sees a same-cycle pop.
  assign if_ready   = rst && (count_q < CNT_FULL) && (state_q != FLUSH);
  assign push       = rdy && !rollback && bus.if_valid && if_ready;
  assign issue      = rdy && !rollback && (state_q != FLUSH) && head_valid && !blocked;

  always_comb begin
    state_d     = state_q;
    fifo_d      = fifo_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    dec_valid_d = 1'b0;
    dec_d       = dec_q;
    stall_d     = stall_q;

    if (rdy) begin
      if (rollback) begin
        state_d = FLUSH;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (push) begin
          fifo_d[tail_q] = '{inst: bus.if_inst, pc: bus.if_pc, is_jump: bus.if_is_jump};
          tail_d         = tail_q + PTR_W'(1);
        end
        if (issue) begin
          dec_d       = head_entry;
          dec_valid_d = 1'b1;
          head_d      = head_q + PTR_W'(1);
        end
        case ({push, issue})
          2'b10:   count_d = count_q + (PTR_W+1)'(1);
          2'b01:   count_d = count_q - (PTR_W+1)'(1);
          default: count_d = count_q;
        endcase
        if ((state_q != FLUSH) && blocked && (stall_q != '1))
          stall_d = stall_q + 32'd1;
        case (state_q)
          RUN:     if (blocked) state_d = STALL;
          STALL:   if (issue || !head_valid) state_d = RUN;
          default: state_d = RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      fifo_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      dec_valid_q <= 1'b0;
      dec_q       <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      fifo_q      <= fifo_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      dec_valid_q <= dec_valid_d;
      dec_q       <= dec_d;
      stall_q     <= stall_d;
    end
  end

  assign bus.if_ready    = if_ready;
  assign bus.dec_valid   = dec_valid_q;
  assign bus.dec_inst    = dec_q.inst;
  assign bus.dec_pc      = dec_q.pc;
  assign bus.dec_is_jump = dec_q.is_jump;
  assign stall_cycles    = stall_q;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: ordered steps with hand-computed expectations.
module tb_dispatch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        rollback;
  logic        rob_full;
  logic        rs_full;
  logic        lsb_full;
  logic [31:0] stall_cycles;
  int          total = 0;
  int          bad   = 0;

  dispatch_ctrl_if bus();

  dispatch_ctrl #(.DEPTH(2), .PTR_W(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .rollback     (rollback),
    .rob_full     (rob_full),
    .rs_full      (rs_full),
    .lsb_full     (lsb_full),
    .bus          (bus.slave),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic j);
    bus.if_valid   = v;
    bus.if_inst    = inst;
    bus.if_pc      = pc;
    bus.if_is_jump = j;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; rollback = 1'b0;
    rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    #2;
    chk("rst_if_ready", {31'b0, bus.if_ready}, 32'd0);
    chk("rst_dec_valid", {31'b0, bus.dec_valid}, 32'd0);
    chk("rst_dec_inst", bus.dec_inst, 32'h0);
    chk("rst_stall", stall_cycles, 32'd0);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("rel_if_ready", {31'b0, bus.if_ready}, 32'd1);

    // basic one-instruction latency
    drive(1'b1, 32'h00500093, 32'h0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("t1_no_bypass", {31'b0, bus.dec_valid}, 32'd0);
    tick();
    chk("t1_valid", {31'b0, bus.dec_valid}, 32'd1);
    chk("t1_inst", bus.dec_inst, 32'h00500093);
    chk("t1_pc", bus.dec_pc, 32'h0);
    chk("t1_stall", stall_cycles, 32'd0);
    tick();
    chk("t1_pulse", {31'b0, bus.dec_valid}, 32'd0);
    chk("t1_hold", bus.dec_inst, 32'h00500093);

    // LW blocked by lsb_full, ADD behind it must wait
    lsb_full = 1'b1;
    drive(1'b1, 32'h00002083, 32'h4, 1'b0);
    tick();
    drive(1'b1, 32'h002081b3, 32'h8, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("t2_full_ready", {31'b0, bus.if_ready}, 32'd0);
    chk("t2_blk1", {31'b0, bus.dec_valid}, 32'd0);
    tick();
    chk("t2_blk2", {31'b0, bus.dec_valid}, 32'd0);
    tick();
    chk("t2_blk3", {31'b0, bus.dec_valid}, 32'd0);
    chk("t2_stall", stall_cycles, 32'd3);
    lsb_full = 1'b0;
    tick();
    chk("t2_lw_valid", {31'b0, bus.dec_valid}, 32'd1);
    chk("t2_lw_inst", bus.dec_inst, 32'h00002083);
    chk("t2_lw_pc", bus.dec_pc, 32'h4);
    chk("t2_lw_jump", {31'b0, bus.dec_is_jump}, 32'd0);
    tick();
    chk("t2_add_valid", {31'b0, bus.dec_valid}, 32'd1);
    chk("t2_add_inst", bus.dec_inst, 32'h002081b3);
    chk("t2_add_pc", bus.dec_pc, 32'h8);
    chk("t2_add_jump", {31'b0, bus.dec_is_jump}, 32'd1);
    chk("t2_stall_end", stall_cycles, 32'd3);
    tick();
    chk("t2_idle", {31'b0, bus.dec_valid}, 32'd0);

    // store goes to LSB, so rs_full does not block it
    rs_full = 1'b1;
    drive(1'b1, 32'h00112023, 32'hC, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("t2b_sw_valid", {31'b0, bus.dec_valid}, 32'd1);
    chk("t2b_sw_inst", bus.dec_inst, 32'h00112023);
    chk("t2b_stall", stall_cycles, 32'd3);
    rs_full = 1'b0;

    // rob_full holds the FIFO full, third instruction waits in ifetch
    rob_full = 1'b1;
    drive(1'b1, 32'h00100113, 32'h10, 1'b0);
    tick();
    drive(1'b1, 32'h00200193, 32'h14, 1'b0);
    tick();
    chk("t3_ready_full", {31'b0, bus.if_ready}, 32'd0);
    drive(1'b1, 32'h00300213, 32'h18, 1'b0);
    tick();
    chk("t3_blocked", {31'b0, bus.dec_valid}, 32'd0);
    chk("t3_ready_held", {31'b0, bus.if_ready}, 32'd0);
    chk("t3_stall", stall_cycles, 32'd5);
    rob_full = 1'b0;
    tick();
    chk("t3_i1_valid", {31'b0, bus.dec_valid}, 32'd1);
    chk("t3_i1_inst", bus.dec_inst, 32'h00100113);
    chk("t3_ready_open", {31'b0, bus.if_ready}, 32'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("t3_i2_valid", {31'b0, bus.dec_valid}, 32'd1);
    chk("t3_i2_inst", bus.dec_inst, 32'h00200193);
    tick();
    chk("t3_i3_valid", {31'b0, bus.dec_valid}, 32'd1);
    chk("t3_i3_inst", bus.dec_inst, 32'h00300213);
    chk("t3_i3_pc", bus.dec_pc, 32'h18);
    chk("t3_stall_end", stall_cycles, 32'd5);
    tick();
    chk("t3_idle", {31'b0, bus.dec_valid}, 32'd0);

    // rollback while stalled with two queued and a concurrent push
    rob_full = 1'b1;
    drive(1'b1, 32'h00400293, 32'h20, 1'b0);
    tick();
    drive(1'b1, 32'h00500313, 32'h24, 1'b0);
    tick();
    chk("t4_stall", stall_cycles, 32'd6);
    rollback = 1'b1;
    drive(1'b1, 32'h00600393, 32'h28, 1'b0);
    tick();
    chk("t4_rb_valid", {31'b0, bus.dec_valid}, 32'd0);
    chk("t4_rb_ready", {31'b0, bus.if_ready}, 32'd0);
    chk("t4_rb_stall", stall_cycles, 32'd6);
    rollback = 1'b0;
    rob_full = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("t4_ready_back", {31'b0, bus.if_ready}, 32'd1);
    chk("t4_no_issue1", {31'b0, bus.dec_valid}, 32'd0);
    tick();
    chk("t4_no_issue2", {31'b0, bus.dec_valid}, 32'd0);
    chk("t4_hold_inst", bus.dec_inst, 32'h00300213);

    // rdy=0 freezes everything, including rollback and push
    rs_full = 1'b1;
    drive(1'b1, 32'h00700413, 32'h30, 1'b0);
    tick();
    rdy = 1'b0;
    rollback = 1'b1;
    drive(1'b1, 32'h00800493, 32'h34, 1'b0);
    for (int unsigned i = 0; i < 4; i++) tick();
    chk("t5_frz_valid", {31'b0, bus.dec_valid}, 32'd0);
    chk("t5_frz_stall", stall_cycles, 32'd6);
    chk("t5_frz_ready", {31'b0, bus.if_ready}, 32'd1);
    rdy = 1'b1;
    rollback = 1'b0;
    rs_full = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("t5_k1_valid", {31'b0, bus.dec_valid}, 32'd1);
    chk("t5_k1_inst", bus.dec_inst, 32'h00700413);
    chk("t5_k1_pc", bus.dec_pc, 32'h30);
    rdy = 1'b0;
    tick();
    chk("t5_rdy0_clear", {31'b0, bus.dec_valid}, 32'd0);
    rdy = 1'b1;

    // asynchronous reset mid-cycle with a queued instruction and dec_valid=1
    drive(1'b1, 32'h00900513, 32'h40, 1'b0);
    tick();
    drive(1'b1, 32'h00a00593, 32'h44, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("t6_pre_valid", {31'b0, bus.dec_valid}, 32'd1);
    chk("t6_pre_inst", bus.dec_inst, 32'h00900513);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_valid", {31'b0, bus.dec_valid}, 32'd0);
    chk("t6_rst_inst", bus.dec_inst, 32'h0);
    chk("t6_rst_pc", bus.dec_pc, 32'h0);
    chk("t6_rst_stall", stall_cycles, 32'd0);
    chk("t6_rst_ready", {31'b0, bus.if_ready}, 32'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("t6_rel_ready", {31'b0, bus.if_ready}, 32'd1);
    tick();
    chk("t6_discarded", {31'b0, bus.dec_valid}, 32'd0);
    drive(1'b1, 32'h00b00613, 32'h48, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("t6_new_valid", {31'b0, bus.dec_valid}, 32'd1);
    chk("t6_new_inst", bus.dec_inst, 32'h00b00613);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
